alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 139 +++++++++++++
 tb/tb_alu_result_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Two-entry in-order result buffer between the ALU and its consumer.
// Flags {N,Z,C,V} are computed when an entry is pushed and stored beside it.
module alu_result_buffer #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] result_i,
  input  logic [3:0]   selection_i,
  input  logic         carry_i,
  input  logic         overflow_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   selection_o,
  output logic [3:0]   flags_o,
  output logic [1:0]   count_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] head_res_q, head_res_d, tail_res_q, tail_res_d;
  logic [3:0]   head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;
  logic [3:0]   head_flg_q, head_flg_d, tail_flg_q, tail_flg_d;
  logic         push_c, pop_c, arith_c;
  logic [3:0]   in_flags_c;

  assign push_c  = valid_i && ready_o;
  assign pop_c   = valid_o && ready_i;
  assign arith_c = (selection_i == 4'b0000) || (selection_i == 4'b0001);
  assign in_flags_c = {result_i[N-1], (result_i == '0),
                       arith_c & carry_i, arith_c & overflow_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_EMPTY;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push_c) state_d = S_ONE;
      S_ONE: begin
        if (push_c && !pop_c)      state_d = S_FULL;
        else if (pop_c && !push_c) state_d = S_EMPTY;
      end
      S_FULL:  if (pop_c) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake and occupancy outputs
  always_comb begin
    ready_o = (state_q != S_FULL) && rst_n_i;
    valid_o = (state_q != S_EMPTY);
    count_o = 2'(state_q);
  end

  // Entry storage; the head is cleared whenever the buffer drains
  always_comb begin
    head_res_d = head_res_q;
    head_sel_d = head_sel_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_sel_d = tail_sel_q;
    tail_flg_d = tail_flg_q;
    case (state_q)
      S_EMPTY: begin
        if (push_c) begin
          head_res_d = result_i;
          head_sel_d = selection_i;
          head_flg_d = in_flags_c;
        end
      end
      S_ONE: begin
        if (push_c && (pop_c || 1'b0)) begin
          head_res_d = result_i;
          head_sel_d = selection_i;
          head_flg_d = in_flags_c;
        end else if (pop_c) begin
          head_res_d = '0;
          head_sel_d = '0;
          head_flg_d = '0;
        end else if (push_c) begin
          tail_res_d = result_i;
          tail_sel_d = selection_i;
          tail_flg_d = in_flags_c;
        end
      end
      S_FULL: begin
        if (pop_c) begin
          head_res_d = tail_res_q;
          head_sel_d = tail_sel_q;
          head_flg_d = tail_flg_q;
          tail_res_d = '0;
          tail_sel_d = '0;
          tail_flg_d = '0;
        end
      end
      default: begin
        head_res_d = '0;
        head_sel_d = '0;
        head_flg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_res_q <= '0;
      head_sel_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_sel_q <= '0;
      tail_flg_q <= '0;
    end else begin
      head_res_q <= head_res_d;
      head_sel_q <= head_sel_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_sel_q <= tail_sel_d;
      tail_flg_q <= tail_flg_d;
    end
  end

  assign result_o    = head_res_q;
  assign selection_o = head_sel_q;
  assign flags_o     = head_flg_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a
// randomized stream compared against a queue-based reference model.
module tb_alu_result_buffer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   sel;
    logic [3:0]   flg;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] result_i = '0;
  logic [3:0]   selection_i = '0;
  logic         carry_i = 1'b0;
  logic         overflow_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] result_o;
  logic [3:0]   selection_o;
  logic [3:0]   flags_o;
  logic [1:0]   count_o;

  int errors = 0;
  int checks = 0;

  alu_result_buffer #(.N(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .selection_i(selection_i), .carry_i(carry_i),
    .overflow_i(overflow_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .selection_o(selection_o), .flags_o(flags_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference entry built straight from the flag rules
  function automatic ent_t mk(input logic [W-1:0] r, input logic [3:0] s,
                              input logic c, input logic v);
    ent_t e;
    bit arith;
    arith = (s < 4'd2);
    e.res = r;
    e.sel = s;
    e.flg = {r[W-1], (r == 0), arith ? c : 1'b0, arith ? v : 1'b0};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] r, input logic [3:0] s,
                       input logic c, input logic o);
    valid_i = v; result_i = r; selection_i = s; carry_i = c; overflow_i = o;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick(); tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 4'h0, 1'b1, 1'b1);
    ready_i = 1'b1;
    tick(); tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if ({result_o, selection_o, flags_o} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", result_o, selection_o, flags_o); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    ready_i = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready_o); end
    @(negedge clk);
  endtask

  task automatic test_single_push();
    drive(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", valid_o); end
    checks++; if (result_o !== 4'b1000) begin errors++; $display("FAIL single_result got=%b exp=1000", result_o); end
    checks++; if (flags_o !== 4'b1011) begin errors++; $display("FAIL single_flags got=%b exp=1011", flags_o); end
    checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count_o); end
    drain();
  endtask

  task automatic test_zero_flags();
    drive(1'b1, 4'b0000, 4'b0010, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (flags_o !== 4'b0100) begin errors++; $display("FAIL zero_flags got=%b exp=0100", flags_o); end
    checks++; if (selection_o !== 4'b0010) begin errors++; $display("FAIL zero_sel got=%b exp=0010", selection_o); end
    drain();
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd12, 4'd0, 1'b0, 1'b0);
    checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", count_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (result_o !== 4'd3 || count_o !== 2'd2) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%0d/%0d exp=3/2", i, result_o, count_o); end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    ready_i = 1'b1;
    tick();
    checks++; if (result_o !== 4'd5 || valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_second got=%0d/%b exp=5/1", result_o, valid_o); end
    tick();
    checks++; if (valid_o !== 1'b0 || result_o !== 4'd0) begin
      errors++; $display("FAIL bp_empty got=%b/%0d exp=0/0", valid_o, result_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_push_pop();
    drive(1'b1, 4'd7, 4'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd9, 4'd1, 1'b1, 1'b0);
    ready_i = 1'b1;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    ready_i = 1'b0;
    checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL pp_count got=%0d exp=1", count_o); end
    checks++; if (result_o !== 4'd9) begin errors++; $display("FAIL pp_result got=%0d exp=9", result_o); end
    checks++; if (flags_o !== 4'b1010) begin errors++; $display("FAIL pp_flags got=%b exp=1010", flags_o); end
    drain();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    tick();
    checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL mr_full got=%0d exp=2", count_o); end
    rst_n = 1'b0;
    drive(1'b1, 4'd6, 4'd0, 1'b0, 1'b0);
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mr_ready_low got=%b exp=0", ready_o); end
    @(negedge clk);
    tick();
    checks++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL mr_state got=%0d/%b exp=0/0", count_o, valid_o); end
    checks++; if ({result_o, selection_o, flags_o} !== '0) begin
      errors++; $display("FAIL mr_data got=%h/%h/%h exp=0/0/0", result_o, selection_o, flags_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mr_ready_during got=%b exp=0", ready_o); end
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mr_ready_after got=%b exp=1", ready_o); end
    @(negedge clk);
    tick();
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL mr_after_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e, head;
    bit   push, pop;
    int   pushed = 0, popped = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 4'($urandom_range(0, 5)),
            1'($urandom), 1'($urandom));
      ready_i = 1'($urandom_range(0, 1));
      #1;
      head = (q.size() > 0) ? q[0] : '0;
      checks++; if (count_o !== 2'(q.size())) begin
        errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count_o, q.size()); end
      checks++; if (valid_o !== (q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_o, q.size() > 0); end
      checks++; if (ready_o !== (q.size() < 2)) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready_o, q.size() < 2); end
      checks++; if ({result_o, selection_o, flags_o} !== head) begin
        errors++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc,
                           result_o, selection_o, flags_o, head.res, head.sel, head.flg); end
      push = valid_i && (q.size() < 2);
      pop  = ready_i && (q.size() > 0);
      e = mk(result_i, selection_i, carry_i, overflow_i);
      @(posedge clk);
      if (pop) begin void'(q.pop_front()); popped++; end
      if (push) begin q.push_back(e); pushed++; end
      @(negedge clk);
    end
    checks++; if (pushed < 100 || popped < 100) begin
      errors++; $display("FAIL rnd_activity got=%0d/%0d exp>=100/100", pushed, popped); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_zero_flags();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
